inst_mem_loader: RTL and testbench

- Writer side of the instruction-memory write port (write enable, address, data) that the fetch stage consumes.
- Receives a framed byte stream from the UART receiver (byte plus done tick) and assembles big-endian 32-bit words.
- Issues one write per word and holds a loading flag that the top level ORs into the pipeline stall while a program is downloaded.

---
 rtl/mips_dbg_pkg.sv | 32 +++
 rtl/loader_timeout.sv | 30 +++
 rtl/inst_mem_loader.sv | 194 +++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared debugger definitions: loader FSM states, command bytes and error codes.
// INST_LOADER_CHECKSUM_EN adds the CSUM state to the loader state enum.
package mips_dbg_pkg;

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2,
        ST_CSUM  = 2'd3
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DATA  = 2'd2
    } loader_state_t;
`endif

    // Debugger command bytes received over the UART link.
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_COUNT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

endpackage

// File: rtl/loader_timeout.sv
// Reloadable down-counter: o_expired flags the TIMEOUT_CYCLES-th consecutive
// running cycle without a reload.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_reload,
    output logic o_expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= LOAD_VAL;
        end else if (!i_run || i_reload) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Fires while the last count is pending so the owner reacts on that edge.
    assign o_expired = i_run && !i_reload && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/inst_mem_loader.sv
// Assembles a framed UART byte stream into big-endian words and writes them to
// instruction memory. INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module inst_mem_loader #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         ADDR_WIDTH     = 32,
    parameter int         MAX_WORDS      = 64,
    parameter logic [7:0] CMD_LOAD       = 8'h4C,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_enable,
    input  logic [7:0]                     i_rx_data,
    input  logic                           i_rx_done,
    output logic                           o_inst_write_enable,
    output logic [ADDR_WIDTH-1:0]          o_write_addr,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    output logic                           o_loading,
    output logic                           o_done,
    output logic [1:0]                     o_error,
    output logic [$clog2(MAX_WORDS+1)-1:0] o_words_loaded,
    output logic [1:0]                     o_state
);
    import mips_dbg_pkg::loader_state_t;
    import mips_dbg_pkg::ST_IDLE;
    import mips_dbg_pkg::ST_COUNT;
    import mips_dbg_pkg::ST_DATA;
    import mips_dbg_pkg::ERR_NONE;
    import mips_dbg_pkg::ERR_COUNT;
    import mips_dbg_pkg::ERR_TIMEOUT;
`ifdef INST_LOADER_CHECKSUM_EN
    import mips_dbg_pkg::ST_CSUM;
    import mips_dbg_pkg::ERR_CSUM;
`endif

    localparam int WC_W = $clog2(MAX_WORDS + 1);

    // Byte handshake: i_rx_data is meaningful only in a cycle with i_rx_done
    // high; there is no backpressure, so every tick is consumed when it arrives.
    loader_state_t                 state_q, state_n;
    logic [DATA_WIDTH-9:0]         asm_q, asm_n;
    logic [1:0]                    bcnt_q, bcnt_n;
    logic [WC_W-1:0]               nwords_q, nwords_n;
    logic                          we_n, done_n, loading_n;
    logic [ADDR_WIDTH-1:0]         addr_n;
    logic [DATA_WIDTH-1:0]         data_n;
    logic [1:0]                    err_n;
    logic [WC_W-1:0]               words_n;
    logic [DATA_WIDTH-1:0]         word_full;
    logic                          expired;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]                    xor_q, xor_n;
`endif

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (state_q != ST_IDLE),
        .i_reload (i_rx_done),
        .o_expired(expired)
    );

    assign word_full = {asm_q, i_rx_data};
    assign o_state   = state_q;

    always_comb begin
        state_n   = state_q;
        asm_n     = asm_q;
        bcnt_n    = bcnt_q;
        nwords_n  = nwords_q;
        we_n      = 1'b0;
        done_n    = 1'b0;
        loading_n = o_loading;
        addr_n    = o_write_addr;
        data_n    = o_write_data;
        err_n     = o_error;
        words_n   = o_words_loaded;
`ifdef INST_LOADER_CHECKSUM_EN
        xor_n     = xor_q;
`endif
        if (state_q != ST_IDLE && expired) begin
            // Partial word is dropped; completed writes stay in memory.
            state_n   = ST_IDLE;
            err_n     = ERR_TIMEOUT;
            loading_n = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    loading_n = 1'b0;
                    if (i_rx_done && i_enable && i_rx_data == CMD_LOAD) begin
                        state_n   = ST_COUNT;
                        err_n     = ERR_NONE;
                        words_n   = '0;
                        bcnt_n    = '0;
                        loading_n = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_n     = '0;
`endif
                    end
                end
                ST_COUNT: begin
                    if (i_rx_done) begin
                        if (i_rx_data == 8'd0) begin
                            state_n   = ST_IDLE;
                            done_n    = 1'b1;
                            loading_n = 1'b0;
                        end else if (int'(i_rx_data) > MAX_WORDS) begin
                            state_n   = ST_IDLE;
                            err_n     = ERR_COUNT;
                            loading_n = 1'b0;
                        end else begin
                            state_n  = ST_DATA;
                            nwords_n = WC_W'(i_rx_data);
                        end
                    end
                end
                ST_DATA: begin
                    if (i_rx_done) begin
                        asm_n  = word_full[DATA_WIDTH-9:0];
                        bcnt_n = bcnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        xor_n  = xor_q ^ i_rx_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            we_n    = 1'b1;
                            addr_n  = ADDR_WIDTH'(o_words_loaded) << 2;
                            data_n  = word_full;
                            words_n = o_words_loaded + WC_W'(1);
                            // o_loading is left high; IDLE drops it one cycle later.
                            if (words_n == nwords_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                                state_n = ST_CSUM;
`else
                                state_n = ST_IDLE;
                                done_n  = 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (i_rx_done) begin
                        state_n = ST_IDLE;
                        if (i_rx_data == xor_q) begin
                            done_n = 1'b1;
                        end else begin
                            err_n = ERR_CSUM;
                        end
                    end
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q             <= ST_IDLE;
            asm_q               <= '0;
            bcnt_q              <= '0;
            nwords_q            <= '0;
            o_inst_write_enable <= 1'b0;
            o_write_addr        <= '0;
            o_write_data        <= '0;
            o_loading           <= 1'b0;
            o_done              <= 1'b0;
            o_error             <= ERR_NONE;
            o_words_loaded      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q               <= '0;
`endif
        end else begin
            state_q             <= state_n;
            asm_q               <= asm_n;
            bcnt_q              <= bcnt_n;
            nwords_q            <= nwords_n;
            o_inst_write_enable <= we_n;
            o_write_addr        <= addr_n;
            o_write_data        <= data_n;
            o_loading           <= loading_n;
            o_done              <= done_n;
            o_error             <= err_n;
            o_words_loaded      <= words_n;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q               <= xor_n;
`endif
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed and randomized frames for inst_mem_loader, checked against a
// byte-list reference model. Honours INST_LOADER_CHECKSUM_EN when defined.
module tb_inst_mem_loader;
    localparam int TO   = 100;
    localparam int MAXW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        inst_write_enable;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        loading;
    logic        done;
    logic [1:0]  error;
    logic [6:0]  words_loaded;
    logic [1:0]  state;

    always #5 clk = ~clk;

    inst_mem_loader #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_enable           (enable),
        .i_rx_data          (rx_data),
        .i_rx_done          (rx_done),
        .o_inst_write_enable(inst_write_enable),
        .o_write_addr       (write_addr),
        .o_write_data       (write_data),
        .o_loading          (loading),
        .o_done             (done),
        .o_error            (error),
        .o_words_loaded     (words_loaded),
        .o_state            (state)
    );

    int          cmp_cnt = 0;
    int          fail_cnt = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  fq[$];
    int          write_cnt, done_cnt, dww_cnt, load_cycles;
    int          edges;
    int          exp_err, exp_words, exp_done, exp_dww, exp_writes, load_kind;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_write_enable) begin
                write_cnt++;
                if (exp_q.size() != 0) check("write_addr_data", {write_addr, write_data}, exp_q.pop_front());
            end
            if (done) done_cnt++;
            if (done && inst_write_enable) dww_cnt++;
            if (loading) load_cycles++;
        end
    end

    task automatic clear_mon();
        write_cnt = 0; done_cnt = 0; dww_cnt = 0; load_cycles = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx_done = 1'b0;
            rx_data = 8'($urandom);
        end
        @(negedge clk);
        rx_data = d;
        rx_done = 1'b1;
        edges += gap + 1;
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    function automatic logic [7:0] xor_bytes(input int first, input int count);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < count; i++) x ^= fq[first + i];
        return x;
    endfunction

    task automatic build_random(input int n);
        fq = {8'h4C, 8'(n)};
        if (n >= 1 && n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) fq.push_back(8'($urandom));
`ifdef INST_LOADER_CHECKSUM_EN
            fq.push_back(xor_bytes(2, 4 * n));
`endif
        end
    endtask

    // Reference: derive writes, result and loading window from the frame bytes.
    task automatic model_frame(input logic en);
        int n;
        exp_writes = 0; exp_done = 0; exp_dww = 0; load_kind = 0;
        if (en && fq[0] == 8'h4C) begin
            n = int'(fq[1]);
            exp_err = 0; exp_words = 0;
            if (n == 0) begin
                exp_done = 1; load_kind = 1;
            end else if (n > MAXW) begin
                exp_err = 1; load_kind = 1;
            end else begin
                load_kind = 2; exp_words = n; exp_writes = n;
                for (int w = 0; w < n; w++)
                    exp_q.push_back({32'(4 * w), fq[2+4*w], fq[3+4*w], fq[4+4*w], fq[5+4*w]});
`ifdef INST_LOADER_CHECKSUM_EN
                if (fq[2 + 4 * n] == xor_bytes(2, 4 * n)) exp_done = 1;
                else exp_err = 3;
`else
                exp_done = 1; exp_dww = 1;
`endif
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
        check({tag, "_loading"}, 64'(loading), 64'd0);
        check({tag, "_state"}, 64'(state), 64'd0);
    endtask

    task automatic run_frame(input string tag, input logic en, input int gmax, input logic wobble);
        int exp_load;
        model_frame(en);
        clear_mon();
        enable = en;
        send_byte(fq[0], $urandom_range(0, gmax));
        edges = 0;
        if (wobble) begin
            @(posedge clk);
            #1 enable = 1'($urandom_range(0, 1));
        end
        for (int i = 1; i < fq.size(); i++) send_byte(fq[i], $urandom_range(0, gmax));
        end_stream();
        repeat (4) @(negedge clk);
        exp_load = (load_kind == 0) ? 0 : (load_kind == 1) ? edges : edges + 1;
        check({tag, "_write_cnt"}, 64'(write_cnt), 64'(exp_writes));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        check({tag, "_done_with_write"}, 64'(dww_cnt), 64'(exp_dww));
        check({tag, "_load_cycles"}, 64'(load_cycles), 64'(exp_load));
        check_idle(tag);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        exp_err = 0; exp_words = 0; edges = 0;
        clear_mon();
        repeat (2) @(negedge clk);
        check("rst_we", 64'(inst_write_enable), 64'd0);
        check("rst_addr", 64'(write_addr), 64'd0);
        check("rst_data", 64'(write_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_idle("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fq = {8'h4C, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h0A};
`ifdef INST_LOADER_CHECKSUM_EN
        fq.push_back(xor_bytes(2, 8));
`endif
        run_frame("two_words", 1'b1, 0, 1'b0);

        fq = {8'h4C, 8'h00};
        run_frame("zero_count", 1'b1, 1, 1'b0);
        fq = {8'h4C, 8'h41};
        run_frame("bad_count", 1'b1, 0, 1'b0);

        // Stalled frame: three bytes of one word, then silence.
        fq = {8'h4C, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        clear_mon();
        enable = 1'b1;
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], 0);
        end_stream();
        n = 0;
        while (error !== 2'b10 && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 64'(n), 64'(TO));
        exp_err = 2; exp_words = 0;
        check("timeout_write_cnt", 64'(write_cnt), 64'd0);
        check("timeout_done_cnt", 64'(done_cnt), 64'd0);
        check_idle("timeout");

        fq = {8'h4C, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef INST_LOADER_CHECKSUM_EN
        fq.push_back(xor_bytes(2, 4));
`endif
        run_frame("disabled", 1'b0, 0, 1'b0);
        run_frame("enabled", 1'b1, 0, 1'b0);

`ifdef INST_LOADER_CHECKSUM_EN
        fq = {8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_frame("csum_good", 1'b1, 0, 1'b0);
        fq = {8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_frame("csum_bad", 1'b1, 0, 1'b0);
`endif

        // Back-to-back 3-word frame cut by reset after the sixth data byte.
        build_random(3);
        exp_q.push_back({32'h0, fq[2], fq[3], fq[4], fq[5]});
        clear_mon();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(fq[i], 0);
        @(negedge clk);
        rx_done = 1'b0;
        rst = 1'b1;
        #1;
        exp_err = 0; exp_words = 0;
        check("mid_rst_we", 64'(inst_write_enable), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_addr", 64'(write_addr), 64'd0);
        check("mid_rst_data", 64'(write_data), 64'd0);
        check_idle("mid_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_write_cnt", 64'(write_cnt), 64'd1);
        check("post_rst_pending", 64'(exp_q.size()), 64'd0);
        check("post_rst_done_cnt", 64'(done_cnt), 64'd0);
        check_idle("post_rst");
        exp_q.delete();

        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 5))
                0:       n = 0;
                1:       n = $urandom_range(MAXW + 1, 255);
                default: n = $urandom_range(1, 6);
            endcase
            build_random(n);
`ifdef INST_LOADER_CHECKSUM_EN
            if (n >= 1 && n <= MAXW && $urandom_range(0, 3) == 0) fq[fq.size() - 1] ^= 8'h01;
`endif
            run_frame("random", 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
